// File: rtl/warmup_pkg.sv
// Shared types, code constants and the expected-code function for the
// warmup counter-code link.
package warmup_pkg;

    // Receiver synchronisation state.
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Code values carried on the link; anything above CODE_OTHER is illegal.
    localparam logic [3:0] CODE_ZERO  = 4'd0;
    localparam logic [3:0] CODE_ONE   = 4'd1;
    localparam logic [3:0] CODE_OTHER = 4'd2;

    // Code the transmitter emits for counter value v.
    function automatic logic [3:0] exp_code(input logic [31:0] v);
        logic [3:0] code;
        if (v == 32'd0) begin
            code = CODE_ZERO;
        end else if (v == 32'd1) begin
            code = CODE_ONE;
        end else begin
            code = CODE_OTHER;
        end
        return code;
    endfunction

endpackage

// File: rtl/warmup_sat_counter.sv
// Saturating event counter. A clear in the same cycle as an increment
// leaves the count at 1 so that the coincident event is not lost.
module warmup_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
    localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: clear wins over hold, increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? ONE_VAL : '0;
        end else if (inc && (count_q != MAX_VAL)) begin
            count_d = count_q + ONE_VAL;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/warmup_code_tracker.sv
// Receive-side tracker for the counter-code link: locks onto the transmitter's
// counter phase, rebuilds the counter value and counts sequence errors.
//
// Input handshake: code_in is consumed on every rising clk edge where
// code_valid is 1; there is no back-pressure. Cycles with code_valid=0 are
// ignored entirely (state and counters hold, err stays low).
module warmup_code_tracker
    import warmup_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       code_in,
    input  logic             code_valid,
    input  logic             clear_err,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_d;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_d;
    logic             err_q;
    logic [CNT_W-1:0] nxt;

    // Counter value the transmitter should be on for the next valid sample.
    assign nxt = cnt_q + CNT_ONE;

    // Next-state, next counter and mismatch detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (code_valid) begin
            case (state_q)
                HUNT: begin
                    // Only a zero code gives a known phase; errors are not
                    // counted until the first zero has been seen.
                    if (code_in == CODE_ZERO) begin
                        cnt_d   = '0;
                        state_d = ACQUIRE;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (code_in == exp_code(32'(nxt))) begin
                        cnt_d = nxt;
                        // Wrapping back to zero cleanly completes a full period.
                        if ((state_q == ACQUIRE) && (nxt == '0)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (code_in == CODE_ZERO) begin
                            // A zero is itself a phase reference: resync now.
                            cnt_d   = '0;
                            state_d = ACQUIRE;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State, reconstructed counter and error pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    warmup_sat_counter #(
        .W(ERR_W)
    ) u_err_counter (
        .clk  (clk),
        .rst  (reset),
        .inc  (err_d),
        .clr  (clear_err),
        .count(err_count)
    );

    assign cnt_out   = cnt_q;
    assign err       = err_q;
    assign cnt_valid = (state_q != HUNT);
    assign locked    = (state_q == LOCKED);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_warmup_code_tracker.sv
// Bench for warmup_code_tracker: directed scenarios plus random traffic,
// all checked against a period/phase reference model.
module tb_warmup_code_tracker;

    localparam int CNT_W   = 4;
    localparam int ERR_W   = 8;
    localparam int PERIOD  = 1 << CNT_W;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int OW      = CNT_W + 3 + ERR_W;

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             reset;
    logic [3:0]       code_in;
    logic             code_valid;
    logic             clear_err;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_valid;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    warmup_code_tracker #(
        .CNT_W(CNT_W),
        .ERR_W(ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .code_in   (code_in),
        .code_valid(code_valid),
        .clear_err (clear_err),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .state_dbg (state_dbg)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    // The model only remembers whether a zero has been seen since the last
    // loss of sync, the counter value it implies, how many codes have matched
    // since that zero, and the error total.
    bit m_sync;
    int m_cnt;
    int m_clean;
    int m_errs;
    bit m_err;

    logic [OW-1:0] exp_q[$];

    function automatic int code_for(input int v);
        if (v == 0) return 0;
        if (v == 1) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_sync  = 1'b0;
        m_cnt   = 0;
        m_clean = 0;
        m_errs  = 0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit v, input int code, input bit clr);
        bit             mism;
        int             want;
        logic [CNT_W-1:0] c;
        logic [ERR_W-1:0] e;
        bit             lk;
        mism = 1'b0;
        if (v) begin
            if (!m_sync) begin
                if (code == 0) begin
                    m_sync  = 1'b1;
                    m_cnt   = 0;
                    m_clean = 0;
                end
            end else begin
                want = (m_cnt + 1) % PERIOD;
                if (code == code_for(want)) begin
                    m_cnt = want;
                    m_clean++;
                end else begin
                    mism = 1'b1;
                    if (code == 0) begin
                        m_cnt   = 0;
                        m_clean = 0;
                    end else begin
                        m_sync = 1'b0;
                    end
                end
            end
        end
        if (clr) m_errs = mism ? 1 : 0;
        else if (mism) m_errs = (m_errs + 1 > ERR_MAX) ? ERR_MAX : m_errs + 1;
        m_err = mism;
        lk = m_sync && (m_clean >= PERIOD);
        c  = m_cnt[CNT_W-1:0];
        e  = m_errs[ERR_W-1:0];
        exp_q.push_back({c, m_sync, lk, mism, e});
    endtask

    task automatic compare_outputs();
        logic [OW-1:0] e;
        check_eq("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("cnt_out",   cnt_out,   e[OW-1 -: CNT_W]);
            check_eq("cnt_valid", cnt_valid, e[ERR_W+2]);
            check_eq("locked",    locked,    e[ERR_W+1]);
            check_eq("err",       err,       e[ERR_W]);
            check_eq("err_count", err_count, e[ERR_W-1:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input int code, input bit clr);
        code_valid = v;
        code_in    = code[3:0];
        clear_err  = clr;
        @(posedge clk);
        model_step(v, code, clr);
        #1;
        compare_outputs();
    endtask

    // Send the code the transmitter would send next, as far as the model knows.
    task automatic send_good(input int n);
        for (int i = 0; i < n; i++) begin
            if (!m_sync) drive(1'b1, 0, 1'b0);
            else drive(1'b1, code_for((m_cnt + 1) % PERIOD), 1'b0);
        end
    endtask

    // Advance a clean stream until the counter reaches target (bounded).
    task automatic advance_to(input int target);
        for (int i = 0; i < 4 * PERIOD; i++) begin
            if (m_sync && m_cnt == target && m_clean >= PERIOD) break;
            send_good(1);
        end
        check_eq("advance_to", m_cnt, target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int code;
        bit v;
        reset      = 1'b1;
        code_in    = 4'd0;
        code_valid = 1'b0;
        clear_err  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cnt_out",   cnt_out,   0);
        check_eq("rst_cnt_valid", cnt_valid, 0);
        check_eq("rst_locked",    locked,    0);
        check_eq("rst_err",       err,       0);
        check_eq("rst_err_count", err_count, 0);
        reset = 1'b0;

        // Clean lock: 0, 1, 2 x14, 0.
        drive(1'b1, 0, 1'b0);
        check_eq("lock_cv_first0", cnt_valid, 1);
        check_eq("lock_nolock_yet", locked, 0);
        drive(1'b1, 1, 1'b0);
        for (int i = 0; i < PERIOD - 2; i++) drive(1'b1, 2, 1'b0);
        check_eq("lock_cnt15", cnt_out, PERIOD - 1);
        drive(1'b1, 0, 1'b0);
        check_eq("lock_wrap0", cnt_out, 0);
        check_eq("lock_locked", locked, 1);
        check_eq("lock_no_err", err_count, 0);

        // Mismatch to HUNT at cnt_out=5.
        advance_to(5);
        drive(1'b1, 1, 1'b0);
        check_eq("hunt_err", err, 1);
        check_eq("hunt_cnt_hold", cnt_out, 5);
        check_eq("hunt_cv", cnt_valid, 0);
        check_eq("hunt_locked", locked, 0);
        check_eq("hunt_err_count", err_count, 1);
        drive(1'b0, 15, 1'b0);
        check_eq("hunt_err_pulse", err, 0);
        send_good(PERIOD + 1);
        check_eq("relock", locked, 1);

        // Resync on an unexpected zero at cnt_out=7.
        advance_to(7);
        drive(1'b1, 0, 1'b0);
        check_eq("resync_err", err, 1);
        check_eq("resync_cnt", cnt_out, 0);
        check_eq("resync_cv", cnt_valid, 1);
        check_eq("resync_locked", locked, 0);

        // Valid gaps carrying garbage.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) drive(1'b0, ($urandom_range(0, 1) != 0) ? 15 : 3, 1'b0);
            else send_good(1);
        end

        // Saturation, then clear with and without a coincident error.
        for (int i = 0; i < 300; i++) drive(1'b1, 0, 1'b0);
        check_eq("sat_255", err_count, ERR_MAX);
        drive(1'b1, 0, 1'b1);
        check_eq("clr_with_err", err_count, 1);
        drive(1'b0, 0, 1'b1);
        check_eq("clr_alone", err_count, 0);

        // Random traffic: mostly correct codes with occasional faults.
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (!m_sync) code = (r < 5) ? 0 : $urandom_range(0, 15);
            else if (r < 7) code = code_for((m_cnt + 1) % PERIOD);
            else if (r == 7) code = 0;
            else if (r == 8) code = $urandom_range(0, 15);
            else code = 2;
            drive(v, code, ($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset between edges while locked.
        send_good(3 * PERIOD);
        check_eq("pre_rst_locked", locked, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_cnt_out",   cnt_out,   0);
        check_eq("arst_cnt_valid", cnt_valid, 0);
        check_eq("arst_locked",    locked,    0);
        check_eq("arst_err",       err,       0);
        check_eq("arst_err_count", err_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 0, 1'b0);
        check_eq("post_rst_c0", cnt_out, 0);
        check_eq("post_rst_cv0", cnt_valid, 1);
        drive(1'b1, 1, 1'b0);
        check_eq("post_rst_c1", cnt_out, 1);
        drive(1'b1, 2, 1'b0);
        check_eq("post_rst_c2", cnt_out, 2);
        check_eq("post_rst_cv2", cnt_valid, 1);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
